// File: rtl/ycbcr_to_rgb565_pkg.sv
// Shared constants and helpers for the YCbCr -> RGB565 conversion pipeline.
// Coefficients are full-range BT.601 scaled by 256.
package ycbcr_to_rgb565_pkg;

  localparam int COEF_R_CR     = 359;
  localparam int COEF_G_CB     = 88;
  localparam int COEF_G_CR     = 183;
  localparam int COEF_B_CB     = 454;
  localparam int CHROMA_OFFSET = 128;
  localparam int ROUND_CONST   = 128;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  // 9-bit signed chroma times a coefficient below 512 fits in 18 bits;
  // Y<<8 plus up to three products stays well inside 20 bits.
  localparam int PROD_W = 18;
  localparam int SUM_W  = 20;

  function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic [15:0] pack_rgb565(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
    return {r[7 -: R_W], g[7 -: G_W], b[7 -: B_W]};
  endfunction

endpackage

// File: rtl/ycc_clamp8.sv
// Scales a signed fixed-point colour sum back to integer and saturates it
// into the 0..255 range.
module ycc_clamp8 #(
  parameter int SUM_W = 20,
  parameter int SHIFT = 8
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic [7:0]              value
);

  localparam logic signed [SUM_W-1:0] MAX_VAL = SUM_W'(255);

  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    shifted = sum >>> SHIFT;
    if (shifted[SUM_W-1]) begin
      value = 8'd0;
    end else if (shifted > MAX_VAL) begin
      value = 8'hFF;
    end else begin
      value = shifted[7:0];
    end
  end

endmodule

// File: rtl/ycbcr_to_rgb565.sv
// Three-stage YCbCr (full-range BT.601) to RGB565 converter: multiply,
// sum with rounding, then scale/clamp/pack. Syncs travel alongside the data.
module ycbcr_to_rgb565
  import ycbcr_to_rgb565_pkg::*;
#(
  parameter int COEF_FRAC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  img_Y,
  input  logic [7:0]  img_Cb,
  input  logic [7:0]  img_Cr,
  input  logic        img_en_in,
  input  logic        img_href_in,
  input  logic        img_vsync_in,
  output logic [15:0] img_data,
  output logic        img_en,
  output logic        img_href,
  output logic        img_vsync
);

  localparam logic signed [PROD_W-1:0] K_R_CR  = PROD_W'(COEF_R_CR);
  localparam logic signed [PROD_W-1:0] K_G_CB  = PROD_W'(COEF_G_CB);
  localparam logic signed [PROD_W-1:0] K_G_CR  = PROD_W'(COEF_G_CR);
  localparam logic signed [PROD_W-1:0] K_B_CB  = PROD_W'(COEF_B_CB);
  localparam logic signed [SUM_W-1:0]  K_ROUND = SUM_W'(ROUND_CONST);
  localparam logic [8:0]               K_OFFSET = 9'(CHROMA_OFFSET);

  logic signed [8:0]        cb_off;
  logic signed [8:0]        cr_off;
  logic signed [PROD_W-1:0] cb_ext;
  logic signed [PROD_W-1:0] cr_ext;

  logic signed [SUM_W-1:0]  y_sh_next;
  logic signed [SUM_W-1:0]  y_sh_reg;
  logic signed [PROD_W-1:0] prod_next [4];
  logic signed [PROD_W-1:0] prod_reg  [4];
  logic signed [SUM_W-1:0]  sum_next  [3];
  logic signed [SUM_W-1:0]  sum_reg   [3];
  logic [7:0]               chan      [3];

  logic [1:0] en_pipe_reg;
  logic [1:0] href_pipe_reg;
  logic [1:0] vsync_pipe_reg;

  // Stage 1 inputs: offset chroma is exact in 9-bit two's complement.
  assign cb_off    = $signed({1'b0, img_Cb} - K_OFFSET);
  assign cr_off    = $signed({1'b0, img_Cr} - K_OFFSET);
  assign cb_ext    = {{(PROD_W-9){cb_off[8]}}, cb_off};
  assign cr_ext    = {{(PROD_W-9){cr_off[8]}}, cr_off};
  assign y_sh_next = SUM_W'(img_Y) << COEF_FRAC;

  assign prod_next[0] = cr_ext * K_R_CR;
  assign prod_next[1] = cb_ext * K_G_CB;
  assign prod_next[2] = cr_ext * K_G_CR;
  assign prod_next[3] = cb_ext * K_B_CB;

  // Stage 2 inputs: rounding bias is folded in before the later shift.
  assign sum_next[0] = y_sh_reg + sext_prod(prod_reg[0]) + K_ROUND;
  assign sum_next[1] = y_sh_reg - sext_prod(prod_reg[1]) - sext_prod(prod_reg[2]) + K_ROUND;
  assign sum_next[2] = y_sh_reg + sext_prod(prod_reg[3]) + K_ROUND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sh_reg <= '0;
      for (int i = 0; i < 4; i++) prod_reg[i] <= '0;
      for (int i = 0; i < 3; i++) sum_reg[i]  <= '0;
    end else begin
      y_sh_reg <= y_sh_next;
      for (int i = 0; i < 4; i++) prod_reg[i] <= prod_next[i];
      for (int i = 0; i < 3; i++) sum_reg[i]  <= sum_next[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clamp
      ycc_clamp8 #(
        .SUM_W (SUM_W),
        .SHIFT (COEF_FRAC)
      ) u_clamp (
        .sum   (sum_reg[gi]),
        .value (chan[gi])
      );
    end
  endgenerate

  // Syncs shift unconditionally; data only updates on valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe_reg    <= '0;
      href_pipe_reg  <= '0;
      vsync_pipe_reg <= '0;
      img_en         <= 1'b0;
      img_href       <= 1'b0;
      img_vsync      <= 1'b0;
      img_data       <= '0;
    end else begin
      en_pipe_reg    <= {en_pipe_reg[0], img_en_in};
      href_pipe_reg  <= {href_pipe_reg[0], img_href_in};
      vsync_pipe_reg <= {vsync_pipe_reg[0], img_vsync_in};
      img_en         <= en_pipe_reg[1];
      img_href       <= href_pipe_reg[1];
      img_vsync      <= vsync_pipe_reg[1];
      if (en_pipe_reg[1]) begin
        img_data <= pack_rgb565(chan[0], chan[1], chan[2]);
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// Self-checking bench for ycbcr_to_rgb565: directed vector table, bubble and
// reset sequences, and a random sweep against a floating-point colour model.
module tb_ycbcr_to_rgb565;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  img_Y = '0;
  logic [7:0]  img_Cb = '0;
  logic [7:0]  img_Cr = '0;
  logic        img_en_in = 1'b0;
  logic        img_href_in = 1'b0;
  logic        img_vsync_in = 1'b0;
  logic [15:0] img_data;
  logic        img_en;
  logic        img_href;
  logic        img_vsync;

  ycbcr_to_rgb565 #(.COEF_FRAC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .img_Y        (img_Y),
    .img_Cb       (img_Cb),
    .img_Cr       (img_Cr),
    .img_en_in    (img_en_in),
    .img_href_in  (img_href_in),
    .img_vsync_in (img_vsync_in),
    .img_data     (img_data),
    .img_en       (img_en),
    .img_href     (img_href),
    .img_vsync    (img_vsync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [15:0] px;
  } vec_t;

  typedef struct {
    logic        en;
    logic        href;
    logic        vs;
    logic [15:0] px;
    bit          fuzzy;
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
  } exp_t;

  exp_t        pipe_q[$];
  logic [15:0] hold_px;
  bit          hold_known;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit chan_ok(input real ref_val, input int obs, input int drop);
    int base;
    int v;
    base = int'(ref_val);
    for (int d = -1; d <= 1; d++) begin
      v = base + d;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      if ((v >> drop) == obs) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic sweep_check(input exp_t e);
    real yr, cbr, crr, r_ref, g_ref, b_ref;
    bit ok;
    yr    = real'(e.y);
    cbr   = real'(e.cb) - 128.0;
    crr   = real'(e.cr) - 128.0;
    r_ref = yr + 1.402 * crr;
    g_ref = yr - 0.344136 * cbr - 0.714136 * crr;
    b_ref = yr + 1.772 * cbr;
    ok = chan_ok(r_ref, int'(img_data[15:11]), 3) &&
         chan_ok(g_ref, int'(img_data[10:5]), 2) &&
         chan_ok(b_ref, int'(img_data[4:0]), 3);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL sweep y=%0d cb=%0d cr=%0d actual=%h required_rgb=%0.2f/%0.2f/%0.2f",
               e.y, e.cb, e.cr, img_data, r_ref, g_ref, b_ref);
    end
  endtask

  // Called at a falling edge: check the outputs owed from three pixels ago,
  // then present the next pixel and advance to the following falling edge.
  task automatic cycle(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                       input logic en, input logic href, input logic vs,
                       input logic [15:0] px, input bit fuzzy);
    exp_t o;
    o = pipe_q.pop_front();
    check_bit("img_en", img_en, o.en);
    check_bit("img_href", img_href, o.href);
    check_bit("img_vsync", img_vsync, o.vs);
    if (o.en) begin
      if (o.fuzzy) begin
        sweep_check(o);
        hold_known = 1'b0;
      end else begin
        $display("pixel y=%0d cb=%0d cr=%0d data=%h expect=%h", o.y, o.cb, o.cr, img_data, o.px);
        check16("img_data", img_data, o.px);
        hold_px    = o.px;
        hold_known = 1'b1;
      end
    end else if (hold_known) begin
      check16("img_data_hold", img_data, hold_px);
    end
    img_Y        = y;
    img_Cb       = cb;
    img_Cr       = cr;
    img_en_in    = en;
    img_href_in  = href;
    img_vsync_in = vs;
    pipe_q.push_back('{en: en, href: href, vs: vs, px: px, fuzzy: fuzzy, y: y, cb: cb, cr: cr});
    @(negedge clk);
  endtask

  task automatic reset_pipe();
    pipe_q.delete();
    for (int i = 0; i < 3; i++)
      pipe_q.push_back('{en: 1'b0, href: 1'b0, vs: 1'b0, px: 16'h0, fuzzy: 1'b0,
                         y: 8'd0, cb: 8'd0, cr: 8'd0});
    hold_px    = 16'h0000;
    hold_known = 1'b1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cycle(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{y: 8'd128, cb: 8'd128, cr: 8'd128, px: 16'h8410};
    vecs[1] = '{y: 8'd255, cb: 8'd128, cr: 8'd255, px: 16'hFD3F};
    vecs[2] = '{y: 8'd0,   cb: 8'd0,   cr: 8'd0,   px: 16'h0440};
    vecs[3] = '{y: 8'd255, cb: 8'd128, cr: 8'd128, px: 16'hFFFF};
    vecs[4] = '{y: 8'd0,   cb: 8'd128, cr: 8'd128, px: 16'h0000};
    vecs[5] = '{y: 8'd0,   cb: 8'd255, cr: 8'd128, px: 16'h001C};
    vecs[6] = '{y: 8'd100, cb: 8'd128, cr: 8'd200, px: 16'hC98C};
    vecs[7] = '{y: 8'd50,  cb: 8'd30,  cr: 8'd128, px: 16'h32A0};

    // Reset state, with active-looking inputs applied while held in reset.
    img_en_in = 1'b1; img_href_in = 1'b1; img_vsync_in = 1'b1;
    img_Y = 8'd200; img_Cb = 8'd50; img_Cr = 8'd220;
    repeat (4) @(negedge clk);
    check16("reset_data", img_data, 16'h0000);
    check_bit("reset_en", img_en, 1'b0);
    check_bit("reset_href", img_href, 1'b0);
    check_bit("reset_vsync", img_vsync, 1'b0);
    img_en_in = 1'b0; img_href_in = 1'b0; img_vsync_in = 1'b0;
    rst_n = 1'b1;
    reset_pipe();

    // Directed table, back to back.
    for (int i = 0; i < 8; i++)
      cycle(vecs[i].y, vecs[i].cb, vecs[i].cr, 1'b1, 1'b1, 1'b0, vecs[i].px, 1'b0);
    flush(3);

    // Bubbles on img_en_in with independent href/vsync edges.
    cycle(8'd128, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1, 16'h8410, 1'b0);
    cycle(8'd255, 8'd128, 8'd128, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(8'd255, 8'd128, 8'd255, 1'b1, 1'b0, 1'b0, 16'hFD3F, 1'b0);
    cycle(8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 16'h0440, 1'b0);
    cycle(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    flush(4);

    // Mid-stream reset: in-flight pixels must never emerge.
    cycle(8'd255, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    cycle(8'd100, 8'd128, 8'd200, 1'b1, 1'b1, 1'b1, 16'hC98C, 1'b0);
    cycle(8'd50,  8'd30,  8'd128, 1'b1, 1'b1, 1'b1, 16'h32A0, 1'b0);
    cycle(8'd255, 8'd128, 8'd255, 1'b1, 1'b1, 1'b1, 16'hFD3F, 1'b0);
    rst_n = 1'b0;
    #1;
    check16("midreset_data", img_data, 16'h0000);
    check_bit("midreset_en", img_en, 1'b0);
    check_bit("midreset_href", img_href, 1'b0);
    check_bit("midreset_vsync", img_vsync, 1'b0);
    img_en_in = 1'b0; img_href_in = 1'b0; img_vsync_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_pipe();
    flush(4);
    cycle(8'd128, 8'd128, 8'd128, 1'b1, 1'b0, 1'b1, 16'h8410, 1'b0);
    flush(3);

    // Random sweep against the floating-point reference.
    for (int i = 0; i < 10000; i++)
      cycle(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'h0, 1'b1);
    flush(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
